// File: rtl/arp_tx_if.sv
// Request/address side and PHY transmit side of the ARP frame transmitter.
// The ARP control logic drives the master side; the transmitter is the slave.
interface arp_tx_if #(
    parameter int DATA_W = 8
);
    logic              tx_req;
    logic              tx_ready;
    logic              tx_op;
    logic [47:0]       local_mac;
    logic [31:0]       local_ip;
    logic [47:0]       tgt_mac;
    logic [31:0]       tgt_ip;
    logic              tx_en;
    logic [DATA_W-1:0] txd;
    logic              tx_busy;
    logic              tx_done;

    modport master (
        output tx_req, tx_op, local_mac, local_ip, tgt_mac, tgt_ip,
        input  tx_ready, tx_en, txd, tx_busy, tx_done
    );

    modport slave (
        input  tx_req, tx_op, local_mac, local_ip, tgt_mac, tgt_ip,
        output tx_ready, tx_en, txd, tx_busy, tx_done
    );
endinterface

// File: rtl/arp_tx_param.sv
// Parametrised ARP frame transmitter: preamble/SFD, Ethernet+ARP header, zero pad
// and CRC-32 FCS, on an 8-bit GMII or 4-bit MII transmit interface.
module arp_tx_param #(
    parameter int DATA_W       = 8,
    parameter int MIN_PAYLOAD  = 46,
    parameter int IFG_CYCLES   = 12,
    parameter int PREAMBLE_LEN = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    arp_tx_if.slave    bus
);

    typedef enum logic [2:0] {IDLE, PRE, BODY, FCS, IFG} state_t;

    localparam logic [7:0] PRE_LAST  = 8'(PREAMBLE_LEN);
    localparam logic [7:0] BODY_LAST = 8'(13 + MIN_PAYLOAD);
    localparam logic [7:0] IFG_LAST  = 8'(IFG_CYCLES - 1);

    state_t        state, state_nxt;
    logic [7:0]    bcnt;
    logic [7:0]    ifg_cnt;
    logic          ph;
    logic [31:0]   crc;
    logic [31:0]   fcs;
    logic [335:0]  hdr;
    logic [7:0]    cur_byte;
    logic          accept;
    logic          sending;
    logic          beat_end;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    assign accept   = bus.tx_req && (state == IDLE);
    assign sending  = (state == PRE) || (state == BODY) || (state == FCS);
    assign beat_end = (DATA_W == 8) ? 1'b1 : ph;
    assign fcs      = ~crc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = PRE;
            PRE:  if (beat_end && bcnt == PRE_LAST) state_nxt = BODY;
            BODY: if (beat_end && bcnt == BODY_LAST) state_nxt = FCS;
            FCS:  if (beat_end && bcnt == 8'd3) state_nxt = IFG;
            IFG:  if (ifg_cnt == IFG_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ph selects the nibble in MII mode; a byte completes on the high nibble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt    <= 8'd0;
            ph      <= 1'b0;
            ifg_cnt <= 8'd0;
            crc     <= 32'hFFFFFFFF;
        end else begin
            ph      <= (DATA_W == 4 && sending) ? ~ph : 1'b0;
            ifg_cnt <= (state == IFG) ? ifg_cnt + 8'd1 : 8'd0;
            if (state_nxt != state)
                bcnt <= 8'd0;
            else if (sending && beat_end)
                bcnt <= bcnt + 8'd1;
            if (accept)
                crc <= 32'hFFFFFFFF;
            else if (state == BODY && beat_end)
                crc <= crc_byte(crc, cur_byte);
        end
    end

    // Header is latched pre-arranged and shifted out; zeros shifted in form the pad
    always_ff @(posedge clk) begin
        if (accept)
            hdr <= {bus.tx_op ? bus.tgt_mac : 48'hFFFF_FFFF_FFFF,
                    bus.local_mac, 16'h0806,
                    16'h0001, 16'h0800, 8'h06, 8'h04,
                    8'h00, bus.tx_op ? 8'h02 : 8'h01,
                    bus.local_mac, bus.local_ip,
                    bus.tx_op ? bus.tgt_mac : 48'h0, bus.tgt_ip};
        else if (state == BODY && beat_end)
            hdr <= {hdr[327:0], 8'h00};
    end

    always_comb begin
        cur_byte = 8'h00;
        case (state)
            PRE:  cur_byte = (bcnt == PRE_LAST) ? 8'hD5 : 8'h55;
            BODY: cur_byte = hdr[335:328];
            FCS: begin
                case (bcnt[1:0])
                    2'd0:    cur_byte = fcs[7:0];
                    2'd1:    cur_byte = fcs[15:8];
                    2'd2:    cur_byte = fcs[23:16];
                    default: cur_byte = fcs[31:24];
                endcase
            end
            default: cur_byte = 8'h00;
        endcase
    end

    assign bus.tx_ready = (state == IDLE);
    assign bus.tx_busy  = (state != IDLE);
    assign bus.tx_en    = sending;
    assign bus.tx_done  = (state == IFG) && (ifg_cnt == 8'd0);

    generate
        if (DATA_W == 8) begin : g_gmii
            assign bus.txd = sending ? cur_byte : 8'h00;
        end else begin : g_mii
            assign bus.txd = sending ? (ph ? cur_byte[7:4] : cur_byte[3:0]) : 4'h0;
        end
    endgenerate

endmodule

// File: tb/tb_arp_tx_param.sv
// Scoreboard bench for arp_tx_param: GMII instance (defaults) and MII instance
// (MIN_PAYLOAD=60, PREAMBLE_LEN=3) share one clock.
module tb_arp_tx_param;

    logic clk = 1'b0;
    logic rst_n8, rst_n4;
    always #5 clk = ~clk;

    arp_tx_if #(.DATA_W(8)) bus8 ();
    arp_tx_if #(.DATA_W(4)) bus4 ();

    arp_tx_param #(.DATA_W(8)) dut8 (.clk(clk), .rst_n(rst_n8), .bus(bus8));
    arp_tx_param #(.DATA_W(4), .MIN_PAYLOAD(60), .PREAMBLE_LEN(3)) dut4
        (.clk(clk), .rst_n(rst_n4), .bus(bus4));

    localparam logic [47:0] LM   = 48'h0011_2233_4455;
    localparam logic [31:0] LIP  = 32'hC0A8_010A;
    localparam logic [31:0] TIP  = 32'hC0A8_0166;
    localparam logic [47:0] TMR  = 48'hA0B1_C2D3_E4F5;
    localparam logic [47:0] TMX  = 48'h6677_8899_AABB;

    int n_tot = 0, n_pass = 0, cyc = 0;

    logic [7:0] exp_q [2][$];
    int         len_q [2][$];
    int         gap_q [2][$];

    int          in_frame [2], cur [2], mism [2], exp_len [2], en_cyc [2];
    int          low_cnt [2], nib_ph [2], done_cnt [2], done_cyc [2], done_pend [2];
    logic [7:0]  nib_lo [2];
    logic [31:0] res [2];
    logic        prev_rdy [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Bit-serial reflected CRC-32 step, LSB of the data byte first
    function automatic logic [31:0] crc_upd(logic [31:0] c, logic [7:0] b);
        logic [31:0] r;
        logic fb;
        r = c;
        for (int j = 0; j < 8; j++) begin
            fb = r[0] ^ b[j];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB88320;
        end
        return r;
    endfunction

    task automatic push_frame(int k, bit op, logic [47:0] lm, logic [31:0] li,
                              logic [47:0] tm, logic [31:0] ti, int gap);
        int p  = (k == 0) ? 7 : 3;
        int mp = (k == 0) ? 46 : 60;
        logic [7:0]   body[$];
        logic [335:0] h;
        logic [31:0]  c;
        h = {op ? tm : 48'hFFFF_FFFF_FFFF, lm, 8'h08, 8'h06,
             8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, op ? 8'h02 : 8'h01,
             lm, li, op ? tm : 48'h0, ti};
        for (int i = 0; i < 42; i++) body.push_back(h[335-8*i -: 8]);
        while (body.size() < 14 + mp) body.push_back(8'h00);
        for (int i = 0; i < p; i++) exp_q[k].push_back(8'h55);
        exp_q[k].push_back(8'hD5);
        c = 32'hFFFFFFFF;
        foreach (body[i]) begin
            c = crc_upd(c, body[i]);
            exp_q[k].push_back(body[i]);
        end
        c = ~c;
        for (int i = 0; i < 4; i++) exp_q[k].push_back(c[8*i +: 8]);
        len_q[k].push_back(p + 1 + 14 + mp + 4);
        gap_q[k].push_back(gap);
    endtask

    task automatic push_abort(int k);
        len_q[k].push_back(-1);
        gap_q[k].push_back(-1);
    endtask

    task automatic mon(int k, logic en, logic [7:0] d, logic done, logic rdy, logic rn);
        logic [7:0] bt, e, dmy;
        logic got;
        int p, g, alen;
        p = (k == 0) ? 7 : 3;
        if (!rn) begin
            if (in_frame[k] != 0) chk("abort_expected", 64'(exp_len[k]), 64'(-1));
            in_frame[k]  = 0;
            done_pend[k] = 0;
            prev_rdy[k]  = 1'b1;
            low_cnt[k]   = 0;
            return;
        end
        if (en) begin
            if (in_frame[k] == 0) begin
                in_frame[k] = 1; cur[k] = 0; mism[k] = 0; en_cyc[k] = 0;
                nib_ph[k] = 0; res[k] = 32'hFFFFFFFF;
                if (len_q[k].size() == 0) begin
                    chk("unexpected_frame", 64'd1, 64'd0);
                    exp_len[k] = -2;
                end else begin
                    exp_len[k] = len_q[k].pop_front();
                    g = gap_q[k].pop_front();
                    if (g >= 0) chk(k == 0 ? "gap_byte" : "gap_nib", 64'(low_cnt[k]), 64'(g));
                end
            end
            en_cyc[k]++;
            got = 1'b0;
            bt  = 8'h00;
            if (k == 0) begin
                bt = d; got = 1'b1;
            end else if (nib_ph[k] == 0) begin
                nib_lo[k] = d; nib_ph[k] = 1;
            end else begin
                bt = {d[3:0], nib_lo[k][3:0]}; nib_ph[k] = 0; got = 1'b1;
            end
            if (got) begin
                if (cur[k] < exp_len[k]) begin
                    e = exp_q[k].pop_front();
                    if (bt !== e) begin
                        if (mism[k] == 0)
                            $display("  dut%0d frame byte %0d: got %02h want %02h", k, cur[k], bt, e);
                        mism[k]++;
                    end
                end
                if (cur[k] > p) res[k] = crc_upd(res[k], bt);
                cur[k]++;
            end
        end else begin
            if (in_frame[k] != 0) begin
                alen = cur[k];
                while (cur[k] < exp_len[k]) begin
                    dmy = exp_q[k].pop_front();
                    cur[k]++;
                end
                chk(k == 0 ? "len_byte" : "len_nib", 64'(alen), 64'(exp_len[k]));
                chk("en_cycles", 64'(en_cyc[k]), 64'(k == 0 ? exp_len[k] : 2 * exp_len[k]));
                chk("frame_bytes_bad", 64'(mism[k]), 64'd0);
                chk("fcs_residue", 64'(res[k]), 64'hDEBB20E3);
                chk("done_at_end", 64'(done), 64'd1);
                in_frame[k] = 0;
                low_cnt[k]  = 0;
            end
            low_cnt[k]++;
            chk("txd_idle_zero", 64'(d), 64'd0);
        end
        if (done) begin
            done_cnt[k]++;
            done_pend[k] = 1;
            done_cyc[k]  = cyc;
        end
        if (rdy && !prev_rdy[k] && done_pend[k] != 0) begin
            chk("ifg_ready", 64'(cyc - done_cyc[k]), 64'd12);
            done_pend[k] = 0;
        end
        prev_rdy[k] = rdy;
    endtask

    always @(negedge clk) begin
        mon(0, bus8.tx_en, bus8.txd, bus8.tx_done, bus8.tx_ready, rst_n8);
        mon(1, bus4.tx_en, {4'h0, bus4.txd}, bus4.tx_done, bus4.tx_ready, rst_n4);
    end

    task automatic set_in(int k, bit req, bit op, logic [47:0] lm, logic [31:0] li,
                          logic [47:0] tm, logic [31:0] ti);
        if (k == 0) begin
            bus8.tx_req = req; bus8.tx_op = op; bus8.local_mac = lm;
            bus8.local_ip = li; bus8.tgt_mac = tm; bus8.tgt_ip = ti;
        end else begin
            bus4.tx_req = req; bus4.tx_op = op; bus4.local_mac = lm;
            bus4.local_ip = li; bus4.tgt_mac = tm; bus4.tgt_ip = ti;
        end
    endtask

    // Called at a negedge with tx_req already high; returns just after the accepting edge
    task automatic wait_acc(int k);
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            if ((k == 0) ? bus8.tx_ready : bus4.tx_ready) begin
                @(posedge clk);
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_done(int k);
        bit ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if ((k == 0) ? bus8.tx_done : bus4.tx_done) ok = 1'b1;
        end
        if (!ok) chk("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before 500000");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n8 = 1'b0;
        rst_n4 = 1'b0;
        set_in(0, 0, 0, 48'h0, 32'h0, 48'h0, 32'h0);
        set_in(1, 0, 0, 48'h0, 32'h0, 48'h0, 32'h0);
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(bus8.tx_ready), 64'd1);
        chk("rst_en", 64'(bus8.tx_en), 64'd0);
        chk("rst_txd", 64'(bus8.txd), 64'd0);
        chk("rst_busy", 64'(bus8.tx_busy), 64'd0);
        chk("rst_done", 64'(bus8.tx_done), 64'd0);
        chk("rst_ready4", 64'(bus4.tx_ready), 64'd1);
        rst_n8 = 1'b1;
        rst_n4 = 1'b1;
        @(negedge clk);

        // ARP request, GMII
        set_in(0, 1, 0, LM, LIP, TMX, TIP);
        wait_acc(0);
        push_frame(0, 0, LM, LIP, TMX, TIP, -1);
        @(negedge clk);
        bus8.tx_req = 1'b0;
        chk("busy_after_acc", 64'(bus8.tx_busy), 64'd1);
        chk("ready_after_acc", 64'(bus8.tx_ready), 64'd0);
        chk("first_beat", 64'({bus8.tx_en, bus8.txd}), 64'h155);
        wait_done(0);

        // ARP reply
        set_in(0, 1, 1, LM, LIP, TMR, TIP);
        wait_acc(0);
        push_frame(0, 1, LM, LIP, TMR, TIP, -1);
        @(negedge clk);
        bus8.tx_req = 1'b0;
        wait_done(0);

        // Back-to-back with tx_req held; next inputs applied while a frame is in flight
        set_in(0, 1, 0, LM, LIP, TMX, 32'h0A00_0001);
        wait_acc(0);
        push_frame(0, 0, LM, LIP, TMX, 32'h0A00_0001, -1);
        @(negedge clk);
        set_in(0, 1, 1, 48'h0200_0000_0001, 32'h0A00_0002, TMR, 32'h0A00_0003);
        wait_acc(0);
        push_frame(0, 1, 48'h0200_0000_0001, 32'h0A00_0002, TMR, 32'h0A00_0003, 13);
        @(negedge clk);
        set_in(0, 1, 0, 48'hFEDC_BA98_7654, 32'hFFFF_FFFF, 48'h1, 32'h0);
        wait_acc(0);
        push_frame(0, 0, 48'hFEDC_BA98_7654, 32'hFFFF_FFFF, 48'h1, 32'h0, 13);
        @(negedge clk);
        bus8.tx_req = 1'b0;
        wait_done(0);

        // Requests during BODY and IFG are ignored
        set_in(0, 1, 1, LM, LIP, TMR, TIP);
        wait_acc(0);
        push_frame(0, 1, LM, LIP, TMR, TIP, -1);
        @(negedge clk);
        bus8.tx_req = 1'b0;
        repeat (14) @(negedge clk);
        set_in(0, 1, 0, 48'hDEAD_BEEF_0000, 32'h1234_5678, 48'h0, 32'h0);
        chk("ready_in_body", 64'(bus8.tx_ready), 64'd0);
        @(negedge clk);
        bus8.tx_req = 1'b0;
        wait_done(0);
        repeat (3) @(negedge clk);
        bus8.tx_req = 1'b1;
        chk("ready_in_ifg", 64'(bus8.tx_ready), 64'd0);
        chk("busy_in_ifg", 64'(bus8.tx_busy), 64'd1);
        @(negedge clk);
        bus8.tx_req = 1'b0;
        repeat (30) @(negedge clk);
        chk("no_extra_frame_en", 64'(bus8.tx_en), 64'd0);
        chk("ready_after_ifg", 64'(bus8.tx_ready), 64'd1);

        // Reset during body byte 20
        set_in(0, 1, 0, LM, LIP, TMX, TIP);
        wait_acc(0);
        push_abort(0);
        repeat (28) @(posedge clk);
        #2 rst_n8 = 1'b0;
        #1;
        chk("rst_async_en", 64'(bus8.tx_en), 64'd0);
        chk("rst_async_txd", 64'(bus8.txd), 64'd0);
        bus8.tx_req = 1'b0;
        repeat (3) @(negedge clk);
        rst_n8 = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 64'(bus8.tx_ready), 64'd1);
        chk("busy_after_rst", 64'(bus8.tx_busy), 64'd0);
        set_in(0, 1, 0, LM, LIP, TMX, TIP);
        wait_acc(0);
        push_frame(0, 0, LM, LIP, TMX, TIP, -1);
        @(negedge clk);
        bus8.tx_req = 1'b0;
        wait_done(0);

        // MII instance: request then reply
        set_in(1, 1, 0, LM, LIP, TMX, TIP);
        wait_acc(1);
        push_frame(1, 0, LM, LIP, TMX, TIP, -1);
        @(negedge clk);
        bus4.tx_req = 1'b0;
        chk("first_nibble", 64'({bus4.tx_en, bus4.txd}), 64'h15);
        wait_done(1);
        set_in(1, 1, 1, LM, LIP, TMR, TIP);
        wait_acc(1);
        push_frame(1, 1, LM, LIP, TMR, TIP, -1);
        @(negedge clk);
        bus4.tx_req = 1'b0;
        wait_done(1);

        repeat (30) @(negedge clk);
        chk("frames_left8", 64'(len_q[0].size()), 64'd0);
        chk("frames_left4", 64'(len_q[1].size()), 64'd0);
        chk("done_count8", 64'(done_cnt[0]), 64'd7);
        chk("done_count4", 64'(done_cnt[1]), 64'd2);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/arp_tx_param.md
Name: arp_tx_param

Overview:
Parametrised ARP frame transmitter; next generation of the board's fixed-field ARP sender. Builds a complete Ethernet II / ARP frame (preamble, SFD, header, ARP body, zero pad, FCS) from runtime-supplied addresses. Computes CRC-32 internally and drives either an 8-bit GMII or a 4-bit MII transmit interface. Sits between the ARP control/cache logic and the MAC/PHY transmit mux.

Parameters:
DATA_W, 8, transmit data width; 8 = GMII byte mode, 4 = MII nibble mode (other values illegal).
MIN_PAYLOAD, 46, minimum Ethernet payload bytes; ARP body (28 bytes) is zero-padded up to this; legal range 28..63.
IFG_CYCLES, 12, idle clock cycles enforced after the last FCS beat before the next request is accepted; legal range 1..255.
PREAMBLE_LEN, 7, number of 0x55 preamble bytes before the SFD byte 0xD5; legal range 1..15.

Ports:
clk  in  1  transmit clock
rst_n  in  1  reset
tx_req  in  1  frame request; accepted on a cycle where tx_req && tx_ready
tx_ready  out  1  block idle and able to accept a request
tx_op  in  1  0 = ARP request, 1 = ARP reply; sampled on acceptance
local_mac  in  48  sender hardware address; sampled on acceptance
local_ip  in  32  sender protocol address; sampled on acceptance
tgt_mac  in  48  target hardware address (reply mode); sampled on acceptance
tgt_ip  in  32  target protocol address; sampled on acceptance
tx_en  out  1  transmit enable to PHY/MAC
txd  out  DATA_W  transmit data
tx_busy  out  1  high from acceptance until end of IFG
tx_done  out  1  one-cycle pulse after the last FCS beat

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. Reset values: tx_ready=1, tx_en=0, txd=0, tx_busy=0, tx_done=0, FSM=IDLE, all counters 0, CRC=0xFFFFFFFF.
- Reset mid-frame: tx_en drops immediately (asynchronously), frame is abandoned, no tx_done is issued, and tx_ready=1 after reset release.
- Handshake: all address/op inputs are latched into internal registers on acceptance. tx_ready=0 and tx_busy=1 from the cycle after acceptance. tx_req while busy is ignored and is not queued.
- FSM states:
  - IDLE: on acceptance, go to PRE.
  - PRE: sends PREAMBLE_LEN bytes of 0x55, then 0xD5, then goes to BODY.
  - BODY: sends byte index 0..(13+MIN_PAYLOAD), then goes to FCS.
  - FCS: sends 4 bytes, then goes to IFG.
  - IFG: counts IFG_CYCLES, then returns to IDLE.
- Latency: the first preamble beat is on txd with tx_en=1 in the cycle after acceptance. tx_en stays high continuously until the last FCS beat inclusive.
- BODY byte order:
  - Eth dst: ff:ff:ff:ff:ff:ff if tx_op=0, else tgt_mac.
  - Eth src: local_mac. Type: 08 06.
  - ARP: 00 01, 08 00, 06, 04, 00 {01|02} (01 when tx_op=0, 02 when tx_op=1).
  - SHA = local_mac. SPA = local_ip.
  - THA = 00..00 if tx_op=0, else tgt_mac. TPA = tgt_ip.
  - Then (MIN_PAYLOAD-28) bytes of 0x00.
  - All multi-byte fields are sent MSB first.
- CRC: IEEE CRC-32 over BODY bytes only.
  - Reflected algorithm, polynomial 0xEDB88320, init 0xFFFFFFFF; updated once per byte as the byte is emitted.
  - FCS = ~crc, sent least-significant byte first.
  - CRC is reinitialised on acceptance.
- Byte mode (DATA_W=8): one byte per cycle. Default frame is 8+14+46+4 = 72 cycles of tx_en.
- Nibble mode (DATA_W=4): each byte takes two cycles, low nibble first; default frame is 144 cycles. Preamble nibbles are 5; the SFD is nibbles 5 then D. The CRC still updates per byte, on the second nibble cycle.
- tx_done: pulses in the first IFG cycle (cycle after the last FCS beat), with tx_en=0 in that cycle.
- IFG boundary: tx_ready rises exactly IFG_CYCLES cycles after the tx_done cycle. A tx_req held continuously high therefore yields back-to-back frames separated by exactly IFG_CYCLES+1 cycles of tx_en low.
- txd holds 0 whenever tx_en=0.

Test Plan:
- Request, DATA_W=8: local_mac=00:11:22:33:44:55, local_ip=192.168.1.10, tgt_ip=192.168.1.102, tx_op=0 -> 72 tx_en cycles; bytes 8..13 = ff; ARP opcode byte 01; THA all 00; 18 pad zeros; FCS equals bench CRC-32 model; decoded frame passes Ethernet FCS check (residue 0xDEBB20E3).
- Reply: tx_op=1, tgt_mac=a0:b1:c2:d3:e4:f5 -> Eth dst and THA = a0:b1:c2:d3:e4:f5; opcode byte 02; FCS correct.
- Back-to-back: tx_req held high for 3 frames -> three frames, each with tx_en low for exactly 13 cycles between frames; one tx_done per frame; inputs changed mid-frame do not corrupt the frame in flight.
- Busy rejection: tx_req pulsed during BODY and during IFG -> no additional frame; tx_ready stays 0 until IFG ends.
- Reset mid-BODY: rst_n asserted at byte 20 -> tx_en=0 immediately, no tx_done; after release, tx_ready=1 and a new request produces a correct full frame.
- DATA_W=4, MIN_PAYLOAD=60, PREAMBLE_LEN=3: request frame -> 2*(4+14+60+4) = 164 tx_en cycles; first nibbles 5,5,5,5,5,5,5,D; 32 pad bytes; nibble-reassembled frame has a valid FCS.
